// File: rtl/part_4_serial_add_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and index sizing.
// The default geometry constants mirror the top-level parameter defaults.
package part_4_serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CHUNK  = 8;
    localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;

    // Keep the chunk index at least one bit wide, even when there is only one chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/part_4_serial_add_chunk_adder.sv
// One CHUNK-bit slice of the serial adder: a + b + cin -> sum, cout.
// Purely combinational; the carry between slices is registered in the parent.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/part_4_serial_add.sv
// Chunk-serial WIDTH-bit adder with valid/ready on both sides.
// One operand pair is added CHUNK bits per clock; the result is held until accepted.
module part_4_serial_add
    import part_4_serial_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: a transfer happens on a posedge where valid and ready are both 1.
    // in_ready is high only in IDLE, out_valid only in DONE; the two never overlap.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [CNT_W-1:0] ops_done,
    output state_t           fsm_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ops_done  <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= 1'b0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // LSB chunk first; operands shift down so the adder always sees bit 0.
                    sum[idx*CHUNK +: CHUNK] <= chunk_sum;
                    carry <= chunk_cout;
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    if (idx == LAST_IDX) begin
                        carry_out <= chunk_cout;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ops_done  <= ops_done + CNT_W'(1);
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
